// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared defaults for the register file with scoreboard
package reg_file_pkg;

    localparam int DEF_DW   = 32;
    localparam int DEF_AW   = 5;
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - read, write, issue and flush signals of the register file
interface reg_file_sb_if
    import reg_file_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
);
    logic [AW-1:0] rsc;
    logic [AW-1:0] rtc;
    logic [DW-1:0] RS;
    logic [DW-1:0] RT;
    logic          rs_busy;
    logic          rt_busy;
    logic          w0_en;
    logic [AW-1:0] w0_addr;
    logic [DW-1:0] w0_data;
    logic          w1_en;
    logic [AW-1:0] w1_addr;
    logic [DW-1:0] w1_data;
    logic          iss_en;
    logic [AW-1:0] iss_addr;
    logic          sb_flush;
    logic [AW:0]   busy_cnt;

    modport master (
        output rsc, rtc, w0_en, w0_addr, w0_data, w1_en, w1_addr, w1_data,
               iss_en, iss_addr, sb_flush,
        input  RS, RT, rs_busy, rt_busy, busy_cnt
    );

    modport slave (
        input  rsc, rtc, w0_en, w0_addr, w0_data, w1_en, w1_addr, w1_data,
               iss_en, iss_addr, sb_flush,
        output RS, RT, rs_busy, rt_busy, busy_cnt
    );

endinterface

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending bits with set/clear/flush and population count
module rf_scoreboard
    import reg_file_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int ZERO_REG = 1
)(
    input  logic              RF_clk,
    input  logic              RF_rstn,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic              w0_en,
    input  logic [AW-1:0]     w0_addr,
    input  logic              w1_en,
    input  logic [AW-1:0]     w1_addr,
    input  logic              sb_flush,
    output logic [2**AW-1:0]  busy,
    output logic [AW:0]       busy_cnt
);

    localparam int            DEPTH     = 2**AW;
    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    logic [DEPTH-1:0] busy_nxt;

    // Flush first, then write-backs clear, then the issue sets: the issue is the newest event.
    always_comb begin
        busy_nxt = busy;
        if (sb_flush)
            busy_nxt = '0;
        if (w0_en)
            busy_nxt[w0_addr] = 1'b0;
        if (w1_en)
            busy_nxt[w1_addr] = 1'b0;
        if (iss_en && !(ZERO_REG != 0 && iss_addr == ZERO_ADDR))
            busy_nxt[iss_addr] = 1'b1;
    end

    always_ff @(posedge RF_clk or negedge RF_rstn) begin
        if (!RF_rstn)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < DEPTH; i++)
            busy_cnt = busy_cnt + {{AW{1'b0}}, busy[i]};
    end

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - two-write, two-read register file with optional bypass and issue scoreboard
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int AW       = DEF_AW,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
)(
    input  logic         RF_clk,
    input  logic         RF_rstn,
    reg_file_sb_if.slave rf
);

    localparam int            DEPTH     = 2**AW;
    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    logic [DW-1:0]    regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [AW-1:0]    rd_addr [2];
    logic [DW-1:0]    rd_data [2];
    logic             wr_hit  [2];

    wire w0_store = rf.w0_en && !(ZERO_REG != 0 && rf.w0_addr == ZERO_ADDR);
    wire w1_store = rf.w1_en && !(ZERO_REG != 0 && rf.w1_addr == ZERO_ADDR);

    // Port 1 is assigned last so it wins an address collision.
    always_ff @(posedge RF_clk or negedge RF_rstn) begin
        if (!RF_rstn) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else begin
            if (w0_store)
                regs[rf.w0_addr] <= rf.w0_data;
            if (w1_store)
                regs[rf.w1_addr] <= rf.w1_data;
        end
    end

    assign rd_addr[0] = rf.rsc;
    assign rd_addr[1] = rf.rtc;

    // Reset gates the bypass path too, so reads are zero for the whole reset window.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = regs[rd_addr[p]];
            wr_hit[p]  = (rf.w0_en && rf.w0_addr == rd_addr[p]) ||
                         (rf.w1_en && rf.w1_addr == rd_addr[p]);
            if (BYPASS != 0 && rd_addr[p] != ZERO_ADDR) begin
                if (rf.w1_en && rf.w1_addr == rd_addr[p])
                    rd_data[p] = rf.w1_data;
                else if (rf.w0_en && rf.w0_addr == rd_addr[p])
                    rd_data[p] = rf.w0_data;
            end
            if ((ZERO_REG != 0 && rd_addr[p] == ZERO_ADDR) || !RF_rstn)
                rd_data[p] = '0;
        end
    end

    assign rf.RS      = rd_data[0];
    assign rf.RT      = rd_data[1];
    assign rf.rs_busy = busy[rf.rsc] && !(BYPASS != 0 && wr_hit[0]);
    assign rf.rt_busy = busy[rf.rtc] && !(BYPASS != 0 && wr_hit[1]);

    rf_scoreboard #(
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .RF_clk   (RF_clk),
        .RF_rstn  (RF_rstn),
        .iss_en   (rf.iss_en),
        .iss_addr (rf.iss_addr),
        .w0_en    (rf.w0_en),
        .w0_addr  (rf.w0_addr),
        .w1_en    (rf.w1_en),
        .w1_addr  (rf.w1_addr),
        .sb_flush (rf.sb_flush),
        .busy     (busy),
        .busy_cnt (rf.busy_cnt)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - bypass and non-bypass register files against a behavioural model
module tb_reg_file_sb;

    logic        RF_clk = 1'b0;
    logic        RF_rstn = 1'b0;
    logic [4:0]  rsc, rtc, w0_addr, w1_addr, iss_addr;
    logic [31:0] w0_data, w1_data;
    logic        w0_en, w1_en, iss_en, sb_flush;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [32];
    logic [31:0] sbusy;

    reg_file_sb_if #(.DW(32), .AW(5)) ifb ();
    reg_file_sb_if #(.DW(32), .AW(5)) ifn ();

    assign ifb.rsc = rsc;           assign ifn.rsc = rsc;
    assign ifb.rtc = rtc;           assign ifn.rtc = rtc;
    assign ifb.w0_en = w0_en;       assign ifn.w0_en = w0_en;
    assign ifb.w0_addr = w0_addr;   assign ifn.w0_addr = w0_addr;
    assign ifb.w0_data = w0_data;   assign ifn.w0_data = w0_data;
    assign ifb.w1_en = w1_en;       assign ifn.w1_en = w1_en;
    assign ifb.w1_addr = w1_addr;   assign ifn.w1_addr = w1_addr;
    assign ifb.w1_data = w1_data;   assign ifn.w1_data = w1_data;
    assign ifb.iss_en = iss_en;     assign ifn.iss_en = iss_en;
    assign ifb.iss_addr = iss_addr; assign ifn.iss_addr = iss_addr;
    assign ifb.sb_flush = sb_flush; assign ifn.sb_flush = sb_flush;

    reg_file_sb #(.DW(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) dut_b (
        .RF_clk (RF_clk), .RF_rstn (RF_rstn), .rf (ifb)
    );
    reg_file_sb #(.DW(32), .AW(5), .ZERO_REG(1), .BYPASS(0)) dut_n (
        .RF_clk (RF_clk), .RF_rstn (RF_rstn), .rf (ifn)
    );

    always #5 RF_clk = ~RF_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural state after each edge.
    always @(posedge RF_clk or negedge RF_rstn) begin
        if (!RF_rstn) begin
            for (int i = 0; i < 32; i++) mem[i] = '0;
            sbusy = '0;
        end else begin
            if (w0_en && w0_addr != 0) mem[w0_addr] = w0_data;
            if (w1_en && w1_addr != 0) mem[w1_addr] = w1_data;
            if (sb_flush) sbusy = '0;
            if (w0_en) sbusy[w0_addr] = 1'b0;
            if (w1_en) sbusy[w1_addr] = 1'b0;
            if (iss_en && iss_addr != 0) sbusy[iss_addr] = 1'b1;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (!RF_rstn || a == 0) return '0;
        if (byp && w1_en && w1_addr == a) return w1_data;
        if (byp && w0_en && w0_addr == a) return w0_data;
        return mem[a];
    endfunction

    function automatic logic [31:0] exp_busy(input logic [4:0] a, input bit byp);
        if (!RF_rstn) return '0;
        if (byp && ((w0_en && w0_addr == a) || (w1_en && w1_addr == a))) return '0;
        return {31'b0, sbusy[a]};
    endfunction

    always @(negedge RF_clk) begin
        chk("b_RS", ifb.RS, exp_rd(rsc, 1));
        chk("b_RT", ifb.RT, exp_rd(rtc, 1));
        chk("b_rs_busy", {31'b0, ifb.rs_busy}, exp_busy(rsc, 1));
        chk("b_rt_busy", {31'b0, ifb.rt_busy}, exp_busy(rtc, 1));
        chk("b_busy_cnt", {26'b0, ifb.busy_cnt}, RF_rstn ? $countones(sbusy) : 0);
        chk("n_RS", ifn.RS, exp_rd(rsc, 0));
        chk("n_RT", ifn.RT, exp_rd(rtc, 0));
        chk("n_rs_busy", {31'b0, ifn.rs_busy}, exp_busy(rsc, 0));
        chk("n_rt_busy", {31'b0, ifn.rt_busy}, exp_busy(rtc, 0));
        chk("n_busy_cnt", {26'b0, ifn.busy_cnt}, RF_rstn ? $countones(sbusy) : 0);
    end

    task automatic idle();
        w0_en = 0; w1_en = 0; iss_en = 0; sb_flush = 0;
        w0_addr = 0; w1_addr = 0; iss_addr = 0; w0_data = 0; w1_data = 0;
    endtask

    task automatic tick();
        @(posedge RF_clk);
        #1;
    endtask

    initial begin
        idle();
        rsc = 0; rtc = 0;
        repeat (2) @(posedge RF_clk);

        // Reset held: traffic is ignored and every address reads zero.
        for (int a = 0; a < 32; a++) begin
            rsc = 5'(a); rtc = 5'(31 - a);
            w0_en = 1; w0_addr = 5'(31 - a); w0_data = $urandom;
            w1_en = 1; w1_addr = 5'(a); w1_data = $urandom;
            iss_en = 1; iss_addr = 5'(a);
            #1;
            chk("rst_b_RS", ifb.RS, 32'h0);
            chk("rst_n_RT", ifn.RT, 32'h0);
            chk("rst_b_cnt", {26'b0, ifb.busy_cnt}, 32'h0);
            chk("rst_b_rs_busy", {31'b0, ifb.rs_busy}, 32'h0);
        end
        idle();
        @(negedge RF_clk);
        RF_rstn = 1;

        // Write-port collision: port 1 wins.
        tick();
        w0_en = 1; w0_addr = 5; w0_data = 32'h1234;
        w1_en = 1; w1_addr = 5; w1_data = 32'hBEEF;
        tick(); idle(); rsc = 5;
        @(negedge RF_clk);
        chk("collide_b", ifb.RS, 32'hBEEF);
        chk("collide_n", ifn.RS, 32'hBEEF);

        // Bypass vs stored read of reg 7, with reg 7 pending.
        tick();
        w0_en = 1; w0_addr = 7; w0_data = 32'h1111_1111; iss_en = 1; iss_addr = 7;
        tick(); idle();
        w1_en = 1; w1_addr = 7; w1_data = 32'hA5A5_A5A5; rtc = 7;
        @(negedge RF_clk);
        chk("byp_b_RT", ifb.RT, 32'hA5A5_A5A5);
        chk("byp_b_rt_busy", {31'b0, ifb.rt_busy}, 32'h0);
        chk("byp_n_RT", ifn.RT, 32'h1111_1111);
        chk("byp_n_rt_busy", {31'b0, ifn.rt_busy}, 32'h1);

        // Register 0 stays zero and never goes pending.
        tick(); idle();
        w0_en = 1; w0_addr = 0; w0_data = 32'hFFFF_FFFF; iss_en = 1; iss_addr = 0; rsc = 0;
        @(negedge RF_clk);
        chk("r0_b_same", ifb.RS, 32'h0);
        tick(); idle(); rsc = 0;
        @(negedge RF_clk);
        chk("r0_b_RS", ifb.RS, 32'h0);
        chk("r0_n_RS", ifn.RS, 32'h0);
        chk("r0_cnt", {26'b0, ifb.busy_cnt}, 32'h0);

        // Scoreboard count, issue-over-write, flush-with-issue.
        tick(); iss_en = 1; iss_addr = 3;
        tick(); iss_en = 1; iss_addr = 4;
        tick(); iss_en = 1; iss_addr = 9;
        tick(); idle();
        @(negedge RF_clk);
        chk("sb_cnt3", {26'b0, ifb.busy_cnt}, 32'd3);
        tick(); w0_en = 1; w0_addr = 4; w0_data = 32'h44; iss_en = 1; iss_addr = 4;
        tick(); idle(); rsc = 4;
        @(negedge RF_clk);
        chk("sb_iss_wr_cnt", {26'b0, ifb.busy_cnt}, 32'd3);
        chk("sb_iss_wr_busy", {31'b0, ifn.rs_busy}, 32'h1);
        tick(); sb_flush = 1; iss_en = 1; iss_addr = 2;
        tick(); idle(); rsc = 2;
        @(negedge RF_clk);
        chk("sb_flush_cnt", {26'b0, ifn.busy_cnt}, 32'd1);
        chk("sb_flush_b_busy2", {31'b0, ifb.rs_busy}, 32'h1);
        chk("sb_flush_n_busy2", {31'b0, ifn.rs_busy}, 32'h1);

        // Random traffic checked by the per-cycle compare.
        for (int c = 0; c < 600; c++) begin
            tick();
            w0_en = 1'($urandom_range(0, 1));
            w0_addr = 5'($urandom);
            w0_data = $urandom;
            w1_en = 1'($urandom_range(0, 1));
            w1_addr = ($urandom_range(0, 3) == 0) ? w0_addr : 5'($urandom);
            w1_data = $urandom;
            iss_en = 1'($urandom_range(0, 1));
            iss_addr = ($urandom_range(0, 3) == 0) ? w1_addr : 5'($urandom);
            sb_flush = ($urandom_range(0, 15) == 0);
            rsc = ($urandom_range(0, 2) == 0) ? w1_addr : 5'($urandom);
            rtc = ($urandom_range(0, 2) == 0) ? w0_addr : 5'($urandom);
        end

        // Asynchronous reset between edges after loading data.
        tick(); idle();
        sb_flush = 1; w0_en = 1; w0_addr = 10; w0_data = 32'hCAFE_0010; iss_en = 1; iss_addr = 10;
        tick(); idle(); rsc = 10; rtc = 10;
        @(negedge RF_clk);
        chk("load_RS", ifn.RS, 32'hCAFE_0010);
        chk("load_cnt", {26'b0, ifn.busy_cnt}, 32'd1);
        @(posedge RF_clk);
        #2 RF_rstn = 0;
        #1;
        chk("arst_b_RS", ifb.RS, 32'h0);
        chk("arst_n_RT", ifn.RT, 32'h0);
        chk("arst_cnt", {26'b0, ifb.busy_cnt}, 32'h0);
        chk("arst_rs_busy", {31'b0, ifn.rs_busy}, 32'h0);
        #4;
        w1_en = 1; w1_addr = 10; w1_data = 32'h77;
        RF_rstn = 1;
        tick(); idle(); rsc = 10; rtc = 11;
        @(negedge RF_clk);
        chk("post_rst_b", ifb.RS, 32'h77);
        chk("post_rst_n", ifn.RS, 32'h77);
        chk("post_rst_cnt", {26'b0, ifn.busy_cnt}, 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
